// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline definitions: register-index width, stage tag layout, NOP tag.
package hazard_scoreboard_pkg;

    localparam int unsigned REG_W = 4;

    typedef struct packed {
        logic [REG_W-1:0] dest;
        logic             wb_en;
        logic             mem_r_en;
    } tag_t;

    localparam tag_t NOP_TAG = '{dest: '0, wb_en: 1'b0, mem_r_en: 1'b0};

    // A source operand depends on a stage when that stage will write its register
    function automatic logic tag_hit(input logic [REG_W-1:0] src, input tag_t t);
        return t.wb_en && (t.dest == src);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_dest_tag_stage.sv
// One pipeline stage of destination-tag bookkeeping.
module dest_tag_stage
    import hazard_scoreboard_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load_en,
    input  logic flush,
    input  tag_t d,
    output tag_t q
);

    // Capture the incoming tag, or a bubble when flushed, unless the pipe is held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= NOP_TAG;
        end else if (load_en) begin
            q <= flush ? NOP_TAG : d;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW hazard detection over the EXE/MEM/WB destination tags, with stall counter.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             forward_en,
    input  logic             freeze,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_two_src,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_wb_en,
    input  logic             id_mem_r_en,
    output logic [REG_W-1:0] exe_dest,
    output logic [REG_W-1:0] mem_dest,
    output logic [REG_W-1:0] wb_dest,
    output logic             exe_wb_en,
    output logic             mem_wb_en,
    output logic             wb_wb_en,
    output logic             exe_mem_r_en,
    output logic             mem_mem_r_en,
    output logic             hazard,
    output logic [15:0]      stall_count
);

    tag_t        id_tag;
    tag_t        exe_q;
    tag_t        mem_q;
    tag_t        wb_q;
    logic        load_en;
    logic        exe_flush;
    logic        exe_hit;
    logic        mem_hit;
    logic [15:0] stall_q;
    logic [15:0] stall_next;
    logic        wb_unused;

    assign id_tag    = '{dest: id_dest, wb_en: id_wb_en, mem_r_en: id_mem_r_en};
    assign load_en   = ~freeze;
    assign exe_flush = hazard | ~id_valid;

    dest_tag_stage u_exe (
        .clk     (clk),
        .rst     (rst),
        .load_en (load_en),
        .flush   (exe_flush),
        .d       (id_tag),
        .q       (exe_q)
    );

    dest_tag_stage u_mem (
        .clk     (clk),
        .rst     (rst),
        .load_en (load_en),
        .flush   (1'b0),
        .d       (exe_q),
        .q       (mem_q)
    );

    dest_tag_stage u_wb (
        .clk     (clk),
        .rst     (rst),
        .load_en (load_en),
        .flush   (1'b0),
        .d       (mem_q),
        .q       (wb_q)
    );

    // Hazard decision from live ID operands against EXE and MEM; WB never stalls
    always_comb begin
        exe_hit = tag_hit(id_src1, exe_q) || (id_two_src && tag_hit(id_src2, exe_q));
        mem_hit = tag_hit(id_src1, mem_q) || (id_two_src && tag_hit(id_src2, mem_q));
        hazard  = 1'b0;
        if (id_valid) begin
            if (forward_en) begin
                hazard = exe_hit && exe_q.mem_r_en;
            end else begin
                hazard = exe_hit || mem_hit;
            end
        end
    end

    // Freeze has priority over a stall; the count saturates instead of wrapping
    assign stall_next = (hazard && !freeze && (stall_q != '1)) ? stall_q + 16'd1 : stall_q;

    // Stall counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_next;
        end
    end

    // WB load flag has no consumer downstream
    assign wb_unused = wb_q.mem_r_en;

    assign exe_dest     = exe_q.dest;
    assign exe_wb_en    = exe_q.wb_en;
    assign exe_mem_r_en = exe_q.mem_r_en;
    assign mem_dest     = mem_q.dest;
    assign mem_wb_en    = mem_q.wb_en;
    assign mem_mem_r_en = mem_q.mem_r_en;
    assign wb_dest      = wb_q.dest;
    assign wb_wb_en     = wb_q.wb_en;
    assign stall_count  = stall_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: directed scenarios plus random traffic.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        forward_en;
    logic        freeze;
    logic        id_valid;
    logic [3:0]  id_src1;
    logic [3:0]  id_src2;
    logic        id_two_src;
    logic [3:0]  id_dest;
    logic        id_wb_en;
    logic        id_mem_r_en;
    logic [3:0]  exe_dest;
    logic [3:0]  mem_dest;
    logic [3:0]  wb_dest;
    logic        exe_wb_en;
    logic        mem_wb_en;
    logic        wb_wb_en;
    logic        exe_mem_r_en;
    logic        mem_mem_r_en;
    logic        hazard;
    logic [15:0] stall_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .forward_en   (forward_en),
        .freeze       (freeze),
        .id_valid     (id_valid),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_two_src   (id_two_src),
        .id_dest      (id_dest),
        .id_wb_en     (id_wb_en),
        .id_mem_r_en  (id_mem_r_en),
        .exe_dest     (exe_dest),
        .mem_dest     (mem_dest),
        .wb_dest      (wb_dest),
        .exe_wb_en    (exe_wb_en),
        .mem_wb_en    (mem_wb_en),
        .wb_wb_en     (wb_wb_en),
        .exe_mem_r_en (exe_mem_r_en),
        .mem_mem_r_en (mem_mem_r_en),
        .hazard       (hazard),
        .stall_count  (stall_count)
    );

    // Reference model: a three-slot pipe of in-flight writers, index 0 = EXE
    logic [3:0]  md [3];
    logic        mw [3];
    logic        mm [3];
    int unsigned mcnt;

    typedef struct {
        string       tag;
        logic [33:0] v;
    } exp_t;

    exp_t exp_q[$];
    event pushed;

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            md[i] = 4'd0;
            mw[i] = 1'b0;
            mm[i] = 1'b0;
        end
        mcnt = 0;
    endfunction

    // Does this operand have to wait, given the forwarding mode?
    function automatic logic operand_blocked(input logic [3:0] s);
        logic in_exe;
        logic in_mem;
        in_exe = mw[0] && (md[0] == s);
        in_mem = mw[1] && (md[1] == s);
        if (forward_en) return in_exe && mm[0];
        return in_exe || in_mem;
    endfunction

    function automatic logic model_hazard();
        if (!id_valid) return 1'b0;
        return operand_blocked(id_src1) || (id_two_src && operand_blocked(id_src2));
    endfunction

    function automatic logic [33:0] model_vec();
        logic [15:0] c;
        c = mcnt[15:0];
        return {model_hazard(), c, md[0], mw[0], mm[0], md[1], mw[1], mm[1], md[2], mw[2]};
    endfunction

    function automatic void model_edge(input logic h);
        if (freeze) return;
        md[2] = md[1]; mw[2] = mw[1]; mm[2] = mm[1];
        md[1] = md[0]; mw[1] = mw[0]; mm[1] = mm[0];
        if (h || !id_valid) begin
            md[0] = 4'd0; mw[0] = 1'b0; mm[0] = 1'b0;
        end else begin
            md[0] = id_dest; mw[0] = id_wb_en; mm[0] = id_mem_r_en;
        end
        if (h && mcnt < 32'd65535) mcnt = mcnt + 1;
    endfunction

    task automatic push_exp(input string tag);
        exp_t e;
        e.tag = tag;
        e.v   = model_vec();
        exp_q.push_back(e);
        -> pushed;
    endtask

    // Monitor: compare every published expectation against the live outputs
    initial begin
        exp_t        e;
        logic [33:0] obs;
        forever begin
            @(pushed);
            while (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                obs = {hazard, stall_count, exe_dest, exe_wb_en, exe_mem_r_en,
                       mem_dest, mem_wb_en, mem_mem_r_en, wb_dest, wb_wb_en};
                total++;
                if (obs !== e.v) begin
                    bad++;
                    $display("FAIL %s: got %h want %h (t=%0t)", e.tag, obs, e.v, $time);
                end
            end
        end
    end

    task automatic set_id(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                          input logic two, input logic [3:0] d, input logic wb, input logic mr);
        id_valid = v; id_src1 = s1; id_src2 = s2; id_two_src = two;
        id_dest = d; id_wb_en = wb; id_mem_r_en = mr;
    endtask

    // Called at a falling edge with inputs applied; returns at the next falling edge
    task automatic tick(input string tag, input bit preload = 1'b0);
        logic h;
        #1;
        h = model_hazard();
        push_exp(tag);
        if (preload) force dut.stall_next = 16'hFFFE;
        @(posedge clk);
        model_edge(h);
        if (preload) mcnt = 32'hFFFE;
        #1;
        if (preload) release dut.stall_next;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        set_id(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) tick("idle");
    endtask

    // Reset pulse placed mid-cycle, checked before the next rising edge
    task automatic async_reset(input string tag);
        #3 rst = 1'b1;
        #1;
        model_reset();
        push_exp(tag);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        forward_en = 1'b0;
        freeze = 1'b0;
        set_id(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        model_reset();
        @(negedge clk);
        #1;
        push_exp("reset_state");
        rst = 1'b0;
        @(negedge clk);

        // Full RAW stall: EXE match then MEM match, then release
        forward_en = 1'b0;
        set_id(1'b1, 4'd1, 4'd2, 1'b0, 4'd3, 1'b1, 1'b0); tick("raw_load_producer");
        set_id(1'b1, 4'd3, 4'd9, 1'b0, 4'd10, 1'b1, 1'b0);
        tick("raw_exe_hit"); tick("raw_mem_hit"); tick("raw_release");
        idle(3);

        // Load-use with src2, then same with src2 not a real operand
        forward_en = 1'b1;
        set_id(1'b1, 4'd0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1); tick("lu_producer");
        set_id(1'b1, 4'd8, 4'd5, 1'b1, 4'd11, 1'b1, 1'b0); tick("lu_src2_hit"); tick("lu_src2_release");
        idle(3);
        set_id(1'b1, 4'd0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1); tick("lu2_producer");
        set_id(1'b1, 4'd8, 4'd5, 1'b0, 4'd11, 1'b1, 1'b0); tick("lu_src2_ignored");
        idle(3);

        // Forwarded ALU result: no stall, producer advances to MEM
        set_id(1'b1, 4'd0, 4'd0, 1'b0, 4'd7, 1'b1, 1'b0); tick("fwd_producer");
        set_id(1'b1, 4'd7, 4'd0, 1'b0, 4'd12, 1'b1, 1'b0); tick("fwd_no_stall"); tick("fwd_mem_dest");
        idle(3);

        // Freeze overrides a pending stall for four cycles
        forward_en = 1'b0;
        set_id(1'b1, 4'd0, 4'd0, 1'b0, 4'd6, 1'b1, 1'b0); tick("frz_producer");
        set_id(1'b1, 4'd6, 4'd0, 1'b0, 4'd13, 1'b1, 1'b0);
        freeze = 1'b1;
        for (int i = 0; i < 4; i++) tick("frz_hold");
        freeze = 1'b0;
        tick("frz_bubble"); tick("frz_mem_stall"); tick("frz_release");
        idle(3);

        // Saturation from a preloaded count
        tick("preload", 1'b1);
        set_id(1'b1, 4'd0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0); tick("sat_producer");
        set_id(1'b1, 4'd2, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0);
        tick("sat_1"); tick("sat_2"); tick("sat_accept");
        set_id(1'b1, 4'd4, 4'd0, 1'b0, 4'd1, 1'b1, 1'b0);
        tick("sat_3"); tick("sat_hold"); tick("sat_accept2");
        idle(2);

        // Asynchronous reset in the middle of a stall
        set_id(1'b1, 4'd0, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0); tick("rst_producer");
        set_id(1'b1, 4'd4, 4'd0, 1'b0, 4'd9, 1'b1, 1'b1); tick("rst_stalling");
        async_reset("rst_mid_stall");
        tick("post_rst_load"); tick("post_rst_shift");
        idle(3);

        // Random traffic over a small register range to provoke collisions
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 9) == 0) forward_en = $urandom_range(0, 1);
            freeze = ($urandom_range(0, 4) == 0);
            set_id($urandom_range(0, 7) != 0, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
                   1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 99) == 0) async_reset("rand_rst");
            else tick("rand");
        end

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) #1;
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port forward_en, input, 1 bit: 1 = forwarding active (load-use stalls only); 0 = full RAW stalls.
REQ-004 SHALL have port freeze, input, 1 bit: memory-stage stall; holds every tag stage and the stall counter.
REQ-005 SHALL have ports id_valid, input, 1 bit, and id_src1, id_src2, input, 4 bits each: ID-stage instruction and its source registers.
REQ-006 SHALL have port id_two_src, input, 1 bit: id_src2 is a real operand.
REQ-007 SHALL have ports id_dest, input, 4 bits; id_wb_en, input, 1 bit; id_mem_r_en, input, 1 bit: ID destination tag, entering EXE.
REQ-008 SHALL have ports exe_dest, mem_dest, wb_dest, output, 4 bits each: per-stage destination tags, driven to the forwarding unit.
REQ-009 SHALL have ports exe_wb_en, mem_wb_en, wb_wb_en, output, 1 bit each: per-stage write-back enables.
REQ-010 SHALL have ports exe_mem_r_en, mem_mem_r_en, output, 1 bit each: load flags.
REQ-011 SHALL have port hazard, output, 1 bit: stall PC and IF/ID; insert bubble into EXE.
REQ-012 SHALL have port stall_count, output, 16 bits: saturating count of hazard cycles.

Function
REQ-013 SHALL hold three tag stages (EXE, MEM, WB); each stage = {dest, wb_en, mem_r_en}.
REQ-014 SHALL, on a clock edge with freeze=0, shift WB<=MEM and MEM<=EXE, and load EXE<=ID tag, or a NOP tag when hazard=1 or id_valid=0.
REQ-015 SHALL, on a clock edge with freeze=1, hold all three stages unchanged.
REQ-016 SHALL define NOP tag as dest=0, wb_en=0, mem_r_en=0.
REQ-017 SHALL compute hazard combinationally from current ID inputs and registered stages; zero-cycle path, no latching.
REQ-018 SHALL define match(s) = (s==exe_dest && exe_wb_en) for the EXE term and (s==mem_dest && mem_wb_en) for the MEM term; src2 participates only when id_two_src=1.
REQ-019 SHALL, with forward_en=0, set hazard=1 when id_valid and either source hits the EXE term or the MEM term.
REQ-020 SHALL, with forward_en=1, set hazard=1 only when id_valid and either source hits the EXE term with exe_mem_r_en=1 (load-use).
REQ-021 SHALL never raise hazard for a WB-stage match; the register file writes on the falling edge.
REQ-022 SHALL force hazard=0 when id_valid=0, even if source tags match.
REQ-023 SHALL, when freeze=1 and hazard=1 in the same cycle, give freeze priority: no bubble is inserted and stall_count does not increment.
REQ-024 SHALL increment stall_count on each edge with hazard=1 and freeze=0, saturating at 16'hFFFF, with no wrap.
REQ-025 SHALL apply a forward_en change to the hazard equation in the same cycle; stage contents are unaffected.

Reset
REQ-026 SHALL, while rst=1, asynchronously clear all stages to NOP tag and stall_count to 0; hazard then follows REQ-022/019/020 with all wb_en=0, i.e. 0.
REQ-027 SHALL, if rst asserts mid-stall, discard pending bubbles and tags; the first post-reset edge loads the ID tag per REQ-014.

Structure
REQ-028 SHALL place the register-index width (4), the stage-tag struct and the NOP tag constant in the shared pipeline package.
REQ-029 SHALL implement each stage as one instance of sub-module dest_tag_stage (async reset, load enable = ~freeze, flush input); three instances total.

Verification
REQ-030 SHALL cover: forward_en=0, EXE holds dest=3 wb_en=1, ID src1=3 -> hazard=1; next edge EXE=NOP, MEM dest=3; hazard stays 1 for one more cycle, then 0.
REQ-031 SHALL cover: forward_en=1, EXE dest=5 wb_en=1 mem_r_en=1, ID src2=5 two_src=1 -> hazard=1 for exactly one cycle; same with two_src=0 -> hazard=0.
REQ-032 SHALL cover: forward_en=1, EXE dest=7 wb_en=1 mem_r_en=0, ID src1=7 -> hazard=0; after one edge mem_dest=7, mem_wb_en=1.
REQ-033 SHALL cover: hazard=1 with freeze=1 for 4 cycles -> stages unchanged and stall_count unchanged; freeze drops -> bubble inserted, stall_count +1.
REQ-034 SHALL cover: preload stall_count=16'hFFFE, then 3 hazard cycles -> stall_count=16'hFFFF, held.
REQ-035 SHALL cover: rst pulse mid-stall, asynchronous to clk -> all *_wb_en=0, hazard=0 and stall_count=0 before the next clk edge.
